fpadd_issue: RTL and testbench
==============================

FPADD_ISSUE -- requirements
Module: fpadd_issue

Interface
REQ-001 Parameter DEPTH, default 4: entries in the operand FIFO and in the result FIFO; power of two, 2..16.
REQ-002 Parameter LAT, default 2: clk edges from a new reg_A/reg_B value to the matching fpadd_single out value; 1..8.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operand pair offered.
REQ-006 in_ready  output  1  operand FIFO can accept.
REQ-007 in_A, in_B  input  32 each  IEEE-754 single operands.
REQ-008 reg_A, reg_B  output  32 each  registered operands driven to fpadd_single reg_A/reg_B.
REQ-009 add_out  input  32  fpadd_single out.
REQ-010 res_valid  output  1  result FIFO non-empty.
REQ-011 res_ready  input  1  downstream consumes the result.
REQ-012 res_data  output  32  result FIFO head, show-ahead.

Function
REQ-013 Accept: in_valid && in_ready at an edge shall push {in_A,in_B} into the operand FIFO.
REQ-014 Ready rule: in_ready = reset high && operand count < DEPTH; no accept at full even if a pop occurs in the same cycle.
REQ-015 Credit rule: issue is permitted when operand FIFO non-empty && (inflight + result count) < DEPTH, using registered values; a same-cycle result pop earns no credit.
REQ-016 Issue: on a permitted edge, pop the head and load it into reg_A/reg_B; otherwise reg_A/reg_B hold their value.
REQ-017 No bypass: an entry accepted at edge E0 issues no earlier than E0+1.
REQ-018 Tracking: a LAT-stage valid shift register is loaded with 1 on issue and 0 otherwise; inflight is its population count.
REQ-019 Capture: at the edge when the last stage is 1, add_out is pushed into the result FIFO.
REQ-020 Credit rule guarantees no result FIFO overflow; no result is ever dropped.
REQ-021 Minimum latency: accept at E0 -> res_valid high after edge E0+1+LAT (3 cycles at defaults).
REQ-022 Pop: res_valid && res_ready at an edge advances the result head; a simultaneous push and pop leaves the count unchanged.
REQ-023 Order: results leave in exact acceptance order.
REQ-024 Throughput: one issue and one result per cycle sustained while inputs are available and res_ready is held high.
REQ-025 Pointers wrap modulo DEPTH; counts are range 0..DEPTH.
REQ-026 No arithmetic on operands; data passes unmodified.

Reset
REQ-027 reset low shall immediately clear both FIFOs, pointers, counts and the valid shift register, and set reg_A = reg_B = 0, res_valid = 0, in_ready = 0.
REQ-028 Reset mid-operation discards all buffered and in-flight pairs; add_out values arriving after release are never captured unless they match a post-reset issue.
REQ-029 First accept is possible at the first edge after reset rises.

Configuration
REQ-030 Macro FPADD_ISSUE_NAN_FLAG_EN defined: add output nan_flag, 1 bit, carried through the operand FIFO, shift register and result FIFO, and aligned with res_data.
REQ-031 nan_flag = 1 iff in_A or in_B has exponent 8'hFF and mantissa != 0; its reset value is 0.
REQ-032 Macro undefined: nan_flag port and all flag storage are absent; other behaviour is identical.

Verification
Bench: registered fpadd_single model, LAT=2.
REQ-033 Basic: in_A=3F800000, in_B=3F800000 accepted at E0, res_ready=1 -> res_valid rises after edge E0+3 with res_data=40000000.
REQ-034 Backpressure: res_ready=0, in_valid held with 10 distinct pairs -> exactly 8 accepted, then in_ready=0; reg_A stops after 4 issues; with res_ready=1, 8 results in order and no loss.
REQ-035 Streaming: 16 pairs on consecutive cycles with res_ready=1 -> res_valid continuous for 16 cycles starting 3 cycles after the first accept, in order.
REQ-036 Reset mid-flight: 2 pairs issued, reset low for 1 cycle -> res_valid=0, reg_A=0, in_ready=0; after release, no result appears for 10 cycles.
REQ-037 NaN flag (macro defined): in_A=7FC00000, in_B=3F800000 -> nan_flag=1 with that result; in_A=7F800000, in_B=3F800000 -> nan_flag=0.

Source files
------------

// File: rtl/fpadd_issue.sv
// Issue/credit wrapper around an external fpadd_single: operand FIFO -> reg_A/reg_B,
// LAT-deep valid tracker, result FIFO. Define FPADD_ISSUE_NAN_FLAG_EN to add nan_flag.
module fpadd_issue #(
  parameter int DEPTH = 4,
  parameter int LAT   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_A,
  input  logic [31:0] in_B,
  output logic [31:0] reg_A,
  output logic [31:0] reg_B,
  input  logic [31:0] add_out,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data
`ifdef FPADD_ISSUE_NAN_FLAG_EN
  ,
  output logic        nan_flag
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
`ifdef FPADD_ISSUE_NAN_FLAG_EN
  localparam int OW = 65;
  localparam int RW = 33;
`else
  localparam int OW = 64;
  localparam int RW = 32;
`endif

  logic [OW-1:0]  r_op_mem [DEPTH];
  logic [AW-1:0]  r_op_wr, r_op_rd;
  logic [CW-1:0]  r_op_cnt;
  logic [RW-1:0]  r_res_mem [DEPTH];
  logic [AW-1:0]  r_res_wr, r_res_rd;
  logic [CW-1:0]  r_res_cnt;
  logic [LAT-1:0] r_vld_pipe;

  logic           w_accept, w_issue, w_capture, w_pop;
  logic [4:0]     w_inflight;
  logic [OW-1:0]  w_op_in, w_op_head;
  logic [RW-1:0]  w_res_in;

  assign in_ready  = reset && (r_op_cnt != CW'(DEPTH));
  assign w_accept  = in_valid && in_ready;
  assign res_valid = (r_res_cnt != '0);
  assign w_pop     = res_valid && res_ready;
  assign w_capture = r_vld_pipe[LAT-1];
  assign w_op_head = r_op_mem[r_op_rd];

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < LAT; i++) w_inflight = w_inflight + 5'(r_vld_pipe[i]);
  end

  // Credits come from registered occupancy only, so a same-cycle result pop never frees a slot early.
  assign w_issue = (r_op_cnt != '0) &&
                   ((6'(w_inflight) + 6'(r_res_cnt)) < 6'(DEPTH));

`ifdef FPADD_ISSUE_NAN_FLAG_EN
  logic [LAT-1:0] r_flag_pipe;
  logic           w_nan_in;
  assign w_nan_in = ((&in_A[30:23]) && (|in_A[22:0])) ||
                    ((&in_B[30:23]) && (|in_B[22:0]));
  assign w_op_in  = {w_nan_in, in_A, in_B};
  assign w_res_in = {r_flag_pipe[LAT-1], add_out};
  assign nan_flag = res_valid && r_res_mem[r_res_rd][32];
`else
  assign w_op_in  = {in_A, in_B};
  assign w_res_in = add_out;
`endif
  assign res_data = r_res_mem[r_res_rd][31:0];

  // Storage arrays carry no reset; pointers and counts define what is live.
  always_ff @(posedge clk) begin
    if (w_accept)  r_op_mem[r_op_wr]   <= w_op_in;
    if (w_capture) r_res_mem[r_res_wr] <= w_res_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op_wr    <= '0;
      r_op_rd    <= '0;
      r_op_cnt   <= '0;
      r_res_wr   <= '0;
      r_res_rd   <= '0;
      r_res_cnt  <= '0;
      r_vld_pipe <= '0;
      reg_A      <= '0;
      reg_B      <= '0;
    end else begin
      if (w_accept) r_op_wr <= r_op_wr + 1'b1;
      if (w_issue) begin
        r_op_rd <= r_op_rd + 1'b1;
        reg_A   <= w_op_head[63:32];
        reg_B   <= w_op_head[31:0];
      end
      r_op_cnt <= r_op_cnt + CW'(w_accept) - CW'(w_issue);

      r_vld_pipe[0] <= w_issue;
      for (int i = 1; i < LAT; i++) r_vld_pipe[i] <= r_vld_pipe[i-1];

      if (w_capture) r_res_wr <= r_res_wr + 1'b1;
      if (w_pop)     r_res_rd <= r_res_rd + 1'b1;
      r_res_cnt <= r_res_cnt + CW'(w_capture) - CW'(w_pop);
    end
  end

`ifdef FPADD_ISSUE_NAN_FLAG_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flag_pipe <= '0;
    end else begin
      r_flag_pipe[0] <= w_issue && w_op_head[64];
      for (int i = 1; i < LAT; i++) r_flag_pipe[i] <= r_flag_pipe[i-1];
    end
  end
`endif

endmodule

// File: tb/tb_fpadd_issue.sv
// Scoreboard bench for fpadd_issue with a one-register fpadd_single stand-in (LAT=2).
module tb_fpadd_issue;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_A = '0, in_B = '0;
  logic [31:0] reg_A, reg_B;
  logic [31:0] add_out = '0;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [31:0] res_data;
`ifdef FPADD_ISSUE_NAN_FLAG_EN
  logic        nan_flag;
`endif

  fpadd_issue #(.DEPTH(4), .LAT(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_A(in_A), .in_B(in_B), .reg_A(reg_A), .reg_B(reg_B), .add_out(add_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
`ifdef FPADD_ISSUE_NAN_FLAG_EN
    , .nan_flag(nan_flag)
`endif
  );

  always #5 clk = ~clk;

  // Adder stand-in: exact for x+x (exponent bump) and for NaN/Inf plus a finite value.
  always @(posedge clk)
    add_out <= (reg_A == reg_B) ? reg_A + 32'h0080_0000 : reg_A;

  // Directed pairs (A == B) and hand-computed sums.
  logic [31:0] tbl_a [16] = '{
    32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h40A0_0000,
    32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000, 32'h4110_0000,
    32'h4120_0000, 32'h4130_0000, 32'h4140_0000, 32'h4150_0000,
    32'h4160_0000, 32'h4170_0000, 32'h4180_0000, 32'h4188_0000};
  logic [31:0] tbl_s [16] = '{
    32'h4080_0000, 32'h40C0_0000, 32'h4100_0000, 32'h4120_0000,
    32'h4140_0000, 32'h4160_0000, 32'h4180_0000, 32'h4190_0000,
    32'h41A0_0000, 32'h41B0_0000, 32'h41C0_0000, 32'h41D0_0000,
    32'h41E0_0000, 32'h41F0_0000, 32'h4200_0000, 32'h4208_0000};

  int n_chk = 0, n_pass = 0;
  logic [32:0] exp_q [$];
  logic [31:0] cur_exp = '0;
  logic        cur_flag = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, req);
  endtask

  // Accept tracker: expected result queued at the edge the pair is taken.
  always @(negedge clk)
    if (reset && in_valid && in_ready) exp_q.push_back({cur_flag, cur_exp});

  // Result monitor.
  always @(negedge clk) begin
    logic [32:0] e;
    if (reset && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", res_data, 32'hxxxx_xxxx);
      end else begin
        e = exp_q.pop_front();
        check("res_data", res_data, e[31:0]);
`ifdef FPADD_ISSUE_NAN_FLAG_EN
        check("nan_flag", 32'(nan_flag), 32'(e[32]));
`endif
      end
    end
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] s, input logic f);
    in_valid = 1'b1; in_A = a; in_B = b; cur_exp = s; cur_flag = f;
  endtask

  task automatic drain(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int acc, iss;
    logic [31:0] prev_a;

    // Reset state
    #2;
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_reg_A", reg_A, 0);
    check("rst_in_ready", 32'(in_ready), 0);
    @(posedge clk); @(posedge clk); #1;

    // Basic: release reset and offer the pair so the first edge after release accepts it
    reset = 1'b1;
    drive(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0);
    #1 check("ready_after_rst", 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      check($sformatf("basic_lat_e%0d", k), 32'(res_valid), 32'(k == 3));
    end
    drain("basic_drain", 10);

    // Backpressure: results blocked, 10 pairs offered
    res_ready = 1'b0;
    acc = 0; iss = 0; prev_a = reg_A;
    for (int c = 0; c < 14; c++) begin
      if (acc < 10) drive(tbl_a[acc], tbl_a[acc], tbl_s[acc], 1'b0);
      else in_valid = 1'b0;
      @(negedge clk);
      if (reg_A != prev_a) iss++;
      prev_a = reg_A;
      if (in_valid && in_ready) acc++;
      @(posedge clk); #1;
    end
    check("bp_accepts", 32'(acc), 8);
    check("bp_in_ready", 32'(in_ready), 0);
    check("bp_issues", 32'(iss), 4);
    in_valid = 1'b0;
    res_ready = 1'b1;
    drain("bp_drain", 40);

    // Streaming: 16 back-to-back pairs, res_valid must be solid for 16 cycles from E0+3
    for (int k = 0; k <= 20; k++) begin
      if (k < 16) drive(tbl_a[k], tbl_a[k], tbl_s[k], 1'b0);
      else in_valid = 1'b0;
      @(posedge clk); #1;
      check($sformatf("stream_vld_e%0d", k), 32'(res_valid), 32'(k >= 3 && k <= 18));
    end
    in_valid = 1'b0;
    drain("stream_drain", 20);

`ifdef FPADD_ISSUE_NAN_FLAG_EN
    drive(32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000, 1'b1);
    @(posedge clk); #1;
    drive(32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain("nan_drain", 20);
`endif

    // Reset mid-flight: two pairs issued, then a one-cycle reset pulse
    drive(tbl_a[4], tbl_a[4], tbl_s[4], 1'b0);
    @(posedge clk); #1;
    drive(tbl_a[5], tbl_a[5], tbl_s[5], 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("midrst_res_valid", 32'(res_valid), 0);
    check("midrst_reg_A", reg_A, 0);
    check("midrst_in_ready", 32'(in_ready), 0);
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      check($sformatf("postrst_quiet_%0d", k), 32'(res_valid), 0);
    end

    // Recovery after reset
    drive(tbl_a[9], tbl_a[9], tbl_s[9], 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain("recover_drain", 10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
